bit_serial_adder_ctrl: RTL and testbench
========================================

BIT_SERIAL_ADDER_CTRL -- requirements
Module: bit_serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock, all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  operand A; captured on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured on an accepted start.
REQ-007 busy  output  1  high while an addition is in progress (state RUN).
REQ-008 done  output  1  one-cycle pulse when the result is valid.
REQ-009 sum  output  WIDTH  result register.
REQ-010 carry_out  output  1  final carry (overflow) of the addition.
REQ-011 x_bitline  output  1  operand A bit currently being processed (for the downstream bitline cell).
REQ-012 y_bitline  output  1  operand B bit currently being processed.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 IDLE -> RUN on a clock edge with start=1; a and b SHALL be captured into internal shift registers, bit index and internal carry cleared to 0, sum cleared to 0.
REQ-015 In RUN, the block SHALL process one bit per cycle LSB-first: x_bitline/y_bitline show bit i of the captured A/B; sum[i] <= x ^ y ^ c; c <= (x&y) | (c&(x^y)).
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1 the FSM SHALL move to DONE and carry_out SHALL load the final carry.
REQ-017 done SHALL be high for exactly the one cycle spent in DONE; latency from the accepting start edge to done high is WIDTH+1 rising edges.
REQ-018 DONE -> RUN if start=1 in that cycle (back-to-back accept, new operands captured); otherwise DONE -> IDLE.
REQ-019 start SHALL be ignored while in RUN; a and b changes during RUN SHALL NOT affect the result.
REQ-020 sum and carry_out SHALL hold their final values from DONE until the next accepted start.
REQ-021 x_bitline and y_bitline SHALL be 0 outside RUN.
REQ-022 busy SHALL equal (state == RUN); busy and done SHALL never be high together.
REQ-023 Arithmetic is unsigned modulo 2^WIDTH, with carry_out the bit-WIDTH carry.

Reset
REQ-024 rst=1 at a clock edge SHALL force state IDLE, busy=0, done=0, sum=0, carry_out=0, x_bitline=0, y_bitline=0, internal carry and bit index 0.
REQ-025 rst SHALL take priority over start and over any in-progress RUN; an aborted addition SHALL produce no done pulse.
REQ-026 The first start SHALL be accepted on the first edge after rst deasserts.

Configuration
REQ-027 Macro BSA_SATURATE_EN: when defined, on entry to DONE with final carry=1 sum SHALL be forced to all ones (carry_out still 1); when undefined, sum is the plain modulo result.

Verification
REQ-028 WIDTH=8, reset, start with a=0x0F b=0x01 -> done after 9 edges, sum=0x10, carry_out=0, busy high exactly 8 cycles.
REQ-029 a=0xFF b=0x01 -> sum=0x00 carry_out=1 (macro undefined); sum=0xFF carry_out=1 (BSA_SATURATE_EN defined).
REQ-030 a=0xA5 b=0x5A, check x_bitline/y_bitline per RUN cycle = 1/0,0/1,1/0,0/1,0/1,1/0,0/1,1/0 -> sum=0xFF, carry_out=0.
REQ-031 start pulsed and a/b changed at RUN cycle 3 -> ignored, original result delivered, single done pulse.
REQ-032 rst asserted at RUN cycle 4 -> next edge all outputs 0, IDLE, no done; a new start then completes normally.
REQ-033 start held high through DONE with new a=0x01 b=0x02 -> RUN re-entered without IDLE, second done gives sum=0x03.

Source files
------------

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial ripple adder with IDLE/RUN/DONE control; one operand bit pair per clock, LSB first.
// Optional BSA_SATURATE_EN: an overflowing result is clamped to all ones on entry to DONE.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             x_bitline,
  output logic             y_bitline
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

`ifdef BSA_SATURATE_EN
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s, input logic c);
    return c ? {WIDTH{1'b1}} : s;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    idx_d     = idx_q;
    c_d       = c_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    busy      = 1'b0;
    done      = 1'b0;
    x_bitline = 1'b0;
    y_bitline = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          idx_d   = '0;
          c_d     = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        x_bitline = a_sh_q[0];
        y_bitline = b_sh_q[0];
        sum_d[idx_q] = x_bitline ^ y_bitline ^ c_q;
        c_d       = (x_bitline & y_bitline) | (c_q & (x_bitline ^ y_bitline));
        // Operands shift right so bit 0 of each register is always the live bit.
        a_sh_d    = a_sh_q >> 1;
        b_sh_d    = b_sh_q >> 1;
        idx_d     = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = c_d;
`ifdef BSA_SATURATE_EN
          sum_d   = sat_sum(sum_d, c_d);
`endif
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          idx_d   = '0;
          c_d     = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Directed bench for bit_serial_adder_ctrl (WIDTH=8): vector table plus
// hand-written start-during-RUN, mid-run reset and back-to-back sequences.
module tb_bit_serial_adder_ctrl;

  localparam int W = 8;
`ifdef BSA_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, x_bitline, y_bitline;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
    .x_bitline(x_bitline), .y_bitline(y_bitline)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_sum(input logic [W-1:0] plain, input logic c);
    return (SAT && c) ? {W{1'b1}} : plain;
  endfunction

  // Called at a falling edge; start is sampled on the following rising edge.
  task automatic kick(input logic [W-1:0] av, input logic [W-1:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
  endtask

  // Counts rising edges until done is seen (bounded), recording the bitlines
  // of each busy cycle. glitch_at>=2 pulses start and scrambles a/b in that RUN cycle.
  task automatic wait_done(input int glitch_at, output int edges, output int bcnt,
                           output int both, output logic [W-1:0] xs, output logic [W-1:0] ys);
    bit got;
    got = 1'b0;
    edges = 0; bcnt = 0; both = 0; xs = '0; ys = '0;
    while (!got && edges < 20) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) start = 1'b0;
      if (glitch_at >= 2 && edges == glitch_at) begin
        start = 1'b1; a = ~a; b = 8'h33;
      end else if (glitch_at >= 2 && edges == glitch_at + 1) begin
        start = 1'b0;
      end
      if (busy && bcnt < W) begin
        xs[bcnt] = x_bitline;
        ys[bcnt] = y_bitline;
      end
      if (busy) bcnt++;
      if (busy && done) both++;
      if (done) got = 1'b1;
    end
  endtask

  int           edges, bcnt, both, dcnt;
  logic [W-1:0] xs, ys;

  initial begin
    vecs[0] = '{8'h0F, 8'h01, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, exp_sum(8'h00, 1'b1), 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    vecs[3] = '{8'h80, 8'h80, exp_sum(8'h00, 1'b1), 1'b1};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'h7F, 8'h7F, 8'hFE, 1'b0};
    vecs[6] = '{8'hC8, 8'h64, exp_sum(8'h2C, 1'b1), 1'b1};
    vecs[7] = '{8'h01, 8'hFE, 8'hFF, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", carry_out, 0);
    check("rst_xy", {x_bitline, y_bitline}, 0);

    // First start is presented together with reset release.
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      kick(vecs[i].a, vecs[i].b);
      wait_done(0, edges, bcnt, both, xs, ys);
      check($sformatf("v%0d_latency", i), edges, W + 1);
      check($sformatf("v%0d_busycnt", i), bcnt, W);
      check($sformatf("v%0d_overlap", i), both, 0);
      check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("v%0d_cout", i), carry_out, vecs[i].cout);
      check($sformatf("v%0d_xbits", i), xs, vecs[i].a);
      check($sformatf("v%0d_ybits", i), ys, vecs[i].b);
      @(posedge clk); @(negedge clk);
      check($sformatf("v%0d_done_clr", i), {busy, done}, 0);
      check($sformatf("v%0d_sum_hold", i), sum, vecs[i].sum);
      check($sformatf("v%0d_cout_hold", i), carry_out, vecs[i].cout);
      check($sformatf("v%0d_xy_idle", i), {x_bitline, y_bitline}, 0);
    end

    // start and operand changes during RUN must be ignored.
    kick(8'h3C, 8'h41);
    wait_done(3, edges, bcnt, both, xs, ys);
    check("glitch_latency", edges, W + 1);
    check("glitch_sum", sum, 8'h7D);
    check("glitch_cout", carry_out, 0);
    dcnt = 0;
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      if (done) dcnt++;
    end
    check("glitch_single_done", dcnt, 0);

    // Reset in RUN cycle 4 aborts without a done pulse.
    kick(8'h0F, 8'hF1);
    repeat (4) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", carry_out, 0);
    check("abort_xy", {x_bitline, y_bitline}, 0);
    rst = 1'b0;
    dcnt = 0;
    repeat (12) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    kick(8'h12, 8'h34);
    wait_done(0, edges, bcnt, both, xs, ys);
    check("after_abort_latency", edges, W + 1);
    check("after_abort_sum", sum, 8'h46);

    // Back-to-back: start asserted during the DONE cycle.
    @(posedge clk); @(negedge clk);
    kick(8'h80, 8'h7F);
    wait_done(0, edges, bcnt, both, xs, ys);
    check("b2b_first_sum", sum, 8'hFF);
    check("b2b_first_done", done, 1);
    kick(8'h01, 8'h02);
    wait_done(0, edges, bcnt, both, xs, ys);
    check("b2b_latency", edges, W + 1);
    check("b2b_busycnt", bcnt, W);
    check("b2b_sum", sum, 8'h03);
    check("b2b_cout", carry_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
